// File: rtl/acondicionador_sensores.sv
// Conditions the two raw IR line sensors: 2-FF synchroniser, per-channel debounce with change
// strobes, and a saturating line-loss timer. All outputs are registered.
module acondicionador_sensores #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned LOST_CYCLES     = 25000000,
  parameter bit          ACTIVE_HIGH     = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic sensor_derecho,
  input  logic sensor_izquierdo,
  output logic sensor_derecho_ok,
  output logic sensor_izquierdo_ok,
  output logic cambio_derecho,
  output logic cambio_izquierdo,
  output logic linea_perdida
);

  localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned LW = $clog2(LOST_CYCLES + 1);

  localparam logic [DW-1:0] DebLast  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [DW-1:0] DebOne   = DW'(1);
  localparam logic [LW-1:0] LostLast = LW'(LOST_CYCLES - 1);
  localparam logic [LW-1:0] LostOne  = LW'(1);

  // Channel index 0 is the right sensor, index 1 the left one.
  logic [1:0]         raw_pol;
  logic [1:0]         meta_q;
  logic [1:0]         sync_q;
  logic [1:0]         filt_q, filt_d;
  logic [1:0]         cambio_q, cambio_d;
  logic [1:0][DW-1:0] deb_cnt_q, deb_cnt_d;
  logic [LW-1:0]      lost_cnt_q, lost_cnt_d;
  logic               perdida_q, perdida_d;

  assign raw_pol = ACTIVE_HIGH ? {sensor_izquierdo, sensor_derecho}
                               : ~{sensor_izquierdo, sensor_derecho};

  always_comb begin
    filt_d    = filt_q;
    cambio_d  = '0;
    deb_cnt_d = deb_cnt_q;
    for (int i = 0; i < 2; i++) begin
      if (sync_q[i] == filt_q[i]) begin
        deb_cnt_d[i] = '0;
      end else if (deb_cnt_q[i] == DebLast) begin
        filt_d[i]    = sync_q[i];
        deb_cnt_d[i] = '0;
        cambio_d[i]  = 1'b1;
      end else begin
        deb_cnt_d[i] = deb_cnt_q[i] + DebOne;
      end
    end
  end

  // Line seen on either channel clears the timer, even on the cycle it would expire.
  always_comb begin
    lost_cnt_d = lost_cnt_q;
    perdida_d  = perdida_q;
    if (filt_q != 2'b00) begin
      lost_cnt_d = '0;
      perdida_d  = 1'b0;
    end else if (lost_cnt_q == LostLast) begin
      perdida_d  = 1'b1;
    end else begin
      lost_cnt_d = lost_cnt_q + LostOne;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta_q     <= '0;
      sync_q     <= '0;
      filt_q     <= '0;
      cambio_q   <= '0;
      deb_cnt_q  <= '0;
      lost_cnt_q <= '0;
      perdida_q  <= 1'b0;
    end else begin
      meta_q     <= raw_pol;
      sync_q     <= meta_q;
      filt_q     <= filt_d;
      cambio_q   <= cambio_d;
      deb_cnt_q  <= deb_cnt_d;
      lost_cnt_q <= lost_cnt_d;
      perdida_q  <= perdida_d;
    end
  end

  assign sensor_derecho_ok   = filt_q[0];
  assign sensor_izquierdo_ok = filt_q[1];
  assign cambio_derecho      = cambio_q[0];
  assign cambio_izquierdo    = cambio_q[1];
  assign linea_perdida       = perdida_q;

endmodule

// File: tb/tb_acondicionador_sensores.sv
// Directed bench for acondicionador_sensores (DEBOUNCE_CYCLES=4, LOST_CYCLES=10); a second
// instance with ACTIVE_HIGH=0 has its raw inputs held at 0.
module tb_acondicionador_sensores;

  logic clk = 1'b0;
  logic rst_n;
  logic der, izq;
  logic der_ok, izq_ok, cambio_der, cambio_izq, lp;
  logic der_b, izq_b;
  logic b_der_ok, b_izq_ok, b_cambio_der, b_cambio_izq, b_lp;

  int vectors     = 0;
  int miscompares = 0;
  logic held;

  always #5 clk = ~clk;

  acondicionador_sensores #(
    .DEBOUNCE_CYCLES(4),
    .LOST_CYCLES    (10),
    .ACTIVE_HIGH    (1'b1)
  ) dut (
    .clk                (clk),
    .reset              (rst_n),
    .sensor_derecho     (der),
    .sensor_izquierdo   (izq),
    .sensor_derecho_ok  (der_ok),
    .sensor_izquierdo_ok(izq_ok),
    .cambio_derecho     (cambio_der),
    .cambio_izquierdo   (cambio_izq),
    .linea_perdida      (lp)
  );

  acondicionador_sensores #(
    .DEBOUNCE_CYCLES(4),
    .LOST_CYCLES    (10),
    .ACTIVE_HIGH    (1'b0)
  ) dut_inv (
    .clk                (clk),
    .reset              (rst_n),
    .sensor_derecho     (der_b),
    .sensor_izquierdo   (izq_b),
    .sensor_derecho_ok  (b_der_ok),
    .sensor_izquierdo_ok(b_izq_ok),
    .cambio_derecho     (b_cambio_der),
    .cambio_izquierdo   (b_cambio_izq),
    .linea_perdida      (b_lp)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    der   = 1'b1;
    izq   = 1'b1;
    der_b = 1'b0;
    izq_b = 1'b0;

    // 1: reset state, then rise 6 cycles after release
    repeat (3) tick();
    chk("rst_der_ok", der_ok, 1'b0);
    chk("rst_izq_ok", izq_ok, 1'b0);
    chk("rst_cambio_der", cambio_der, 1'b0);
    chk("rst_cambio_izq", cambio_izq, 1'b0);
    chk("rst_lp", lp, 1'b0);
    chk("rst_b_der_ok", b_der_ok, 1'b0);
    chk("rst_b_izq_ok", b_izq_ok, 1'b0);
    rst_n = 1'b1;
    repeat (5) tick();
    chk("s1_der_ok_c5", der_ok, 1'b0);
    chk("s1_izq_ok_c5", izq_ok, 1'b0);
    chk("s1_cambio_der_c5", cambio_der, 1'b0);
    chk("s7_b_der_ok_c5", b_der_ok, 1'b0);
    tick();
    chk("s1_der_ok_c6", der_ok, 1'b1);
    chk("s1_izq_ok_c6", izq_ok, 1'b1);
    chk("s1_cambio_der_c6", cambio_der, 1'b1);
    chk("s1_cambio_izq_c6", cambio_izq, 1'b1);
    chk("s7_b_der_ok_c6", b_der_ok, 1'b1);
    chk("s7_b_izq_ok_c6", b_izq_ok, 1'b1);
    chk("s7_b_cambio_der_c6", b_cambio_der, 1'b1);
    tick();
    chk("s1_cambio_der_c7", cambio_der, 1'b0);
    chk("s1_cambio_izq_c7", cambio_izq, 1'b0);
    chk("s1_der_ok_c7", der_ok, 1'b1);
    chk("s1_lp_c7", lp, 1'b0);

    // 2: 3-cycle glitch is rejected, a sustained fall passes after 6 cycles
    der = 1'b0;
    repeat (3) tick();
    der = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("s2_glitch_ok", der_ok, 1'b1);
      chk("s2_glitch_strobe", cambio_der, 1'b0);
    end
    der = 1'b0;
    repeat (5) tick();
    chk("s2_fall_c5", der_ok, 1'b1);
    tick();
    chk("s2_fall_c6", der_ok, 1'b0);
    chk("s2_fall_strobe", cambio_der, 1'b1);
    chk("s2_izq_undisturbed", cambio_izq, 1'b0);

    // 3: both sensors off; loss flag on the 10th both-zero cycle, then held
    izq = 1'b0;
    repeat (6) tick();
    chk("s3_izq_fall", izq_ok, 1'b0);
    chk("s3_izq_strobe", cambio_izq, 1'b1);
    repeat (9) tick();
    chk("s3_lp_cycle9", lp, 1'b0);
    tick();
    chk("s3_lp_cycle10", lp, 1'b1);
    held = 1'b1;
    repeat (110) begin
      tick();
      if (lp !== 1'b1) held = 1'b0;
    end
    chk("s3_lp_saturates", held, 1'b1);

    // 4: left sees line again; loss flag clears one cycle after the filtered rise
    izq = 1'b1;
    repeat (6) tick();
    chk("s4_izq_rise", izq_ok, 1'b1);
    chk("s4_lp_still_set", lp, 1'b1);
    tick();
    chk("s4_lp_clear", lp, 1'b0);

    // 5: both raws toggle on the same edge
    der = 1'b1;
    izq = 1'b0;
    repeat (5) tick();
    chk("s5_cambio_der_c5", cambio_der, 1'b0);
    chk("s5_cambio_izq_c5", cambio_izq, 1'b0);
    tick();
    chk("s5_cambio_der_c6", cambio_der, 1'b1);
    chk("s5_cambio_izq_c6", cambio_izq, 1'b1);
    chk("s5_der_ok", der_ok, 1'b1);
    chk("s5_izq_ok", izq_ok, 1'b0);

    // 6a: reset mid-debounce is asynchronous; timing restarts from zero
    der = 1'b0;
    repeat (4) tick();
    rst_n = 1'b0;
    #1;
    chk("s6_async_der_ok", der_ok, 1'b0);
    chk("s6_async_cambio", cambio_der, 1'b0);
    chk("s6_async_lp", lp, 1'b0);
    chk("s6_async_b_der_ok", b_der_ok, 1'b0);
    der = 1'b1;
    tick();
    rst_n = 1'b1;
    repeat (5) tick();
    chk("s6_der_ok_c5", der_ok, 1'b0);
    tick();
    chk("s6_der_ok_c6", der_ok, 1'b1);
    chk("s6_cambio_c6", cambio_der, 1'b1);

    // 6b: reset mid-timeout discards the partial count
    der = 1'b0;
    repeat (6) tick();
    chk("s6_der_off", der_ok, 1'b0);
    repeat (5) tick();
    rst_n = 1'b0;
    #1;
    chk("s6_lp_in_reset", lp, 1'b0);
    tick();
    rst_n = 1'b1;
    repeat (9) tick();
    chk("s6_lp_cycle9", lp, 1'b0);
    tick();
    chk("s6_lp_cycle10", lp, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
